// File: rtl/softmax_max_sub_pkg.sv
// rtl/softmax_max_sub_pkg.sv - shared defaults, state encoding and widths for softmax_max_sub
package softmax_max_sub_pkg;

  localparam int LANES_DEF   = 8;
  localparam int LANE_W_DEF  = 16;
  localparam int DEPTH_DEF   = 64;

  // Guard bits added to LANE_W so (x - max) cannot wrap before saturation.
  localparam int SAT_GUARD_W = 1;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/softmax_lane_max.sv
// rtl/softmax_lane_max.sv - combinational signed maximum across all lanes of one beat
module softmax_lane_max #(
  parameter int LANES  = 8,
  parameter int LANE_W = 16
) (
  input  logic [LANES*LANE_W-1:0] beat_i,
  output logic signed [LANE_W-1:0] max_o
);

  // Comparator reduction: keep the larger signed lane at each step.
  always_comb begin
    max_o = beat_i[LANE_W-1:0];
    for (int i = 1; i < LANES; i++) begin
      if ($signed(beat_i[i*LANE_W +: LANE_W]) > max_o) begin
        max_o = beat_i[i*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/softmax_max_sub.sv
// rtl/softmax_max_sub.sv - buffers a packet, finds its max, emits lane-wise (x - max) saturated
module softmax_max_sub
  import softmax_max_sub_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [LANES*LANE_W-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [LANES*LANE_W-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    ovf_err
);

  localparam int DW    = LANES * LANE_W;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUB_W = LANE_W + SAT_GUARD_W;
  localparam logic signed [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]          rd_cnt_q, rd_cnt_d;
  logic signed [LANE_W-1:0]  max_q, max_d;
  logic                      ovf_q, ovf_d;
  logic [DW-1:0]             m_tdata_q, m_tdata_d;
  logic                      m_tvalid_q, m_tvalid_d;
  logic                      m_tlast_q, m_tlast_d;

  logic [DW-1:0]             mem_q [DEPTH];
  logic                      wr_en;
  logic [DW-1:0]             rd_beat;
  logic [DW-1:0]             sub_data;
  logic signed [LANE_W-1:0]  beat_max;
  logic                      in_hs;
  logic                      out_hs;
  logic                      out_free;

  assign s_axis_tready = (state_q == ST_FILL);
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign ovf_err       = ovf_q;

  assign in_hs    = s_axis_tvalid && s_axis_tready;
  assign out_hs   = m_tvalid_q && m_axis_tready;
  assign out_free = !m_tvalid_q || m_axis_tready;

  softmax_lane_max #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_lane_max (
    .beat_i (s_axis_tdata),
    .max_o  (beat_max)
  );

  // Packet buffer: synchronous write, asynchronous read, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_cnt_q[AW-1:0]] <= s_axis_tdata;
    end
  end

  assign rd_beat = mem_q[rd_cnt_q[AW-1:0]];

  // Per-lane subtract with one guard bit; results are never positive, so only
  // the negative overflow needs clamping.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [SUB_W-1:0] diff;
    assign diff = {rd_beat[i*LANE_W + LANE_W - 1], rd_beat[i*LANE_W +: LANE_W]}
                - {max_q[LANE_W-1], max_q};
    assign sub_data[i*LANE_W +: LANE_W] =
      (diff[SUB_W-1] != diff[LANE_W-1]) ? LANE_MIN : diff[LANE_W-1:0];
  end

  // Next-state and datapath control for the fill/drain sequence.
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    max_d      = max_q;
    ovf_d      = ovf_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    wr_en      = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (in_hs) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          max_d    = (beat_max > max_q) ? beat_max : max_q;
          if (s_axis_tlast || (wr_cnt_q == CNT_W'(DEPTH - 1))) begin
            state_d = ST_DRAIN;
          end
          if (!s_axis_tlast && (wr_cnt_q == CNT_W'(DEPTH - 1))) begin
            ovf_d = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (out_hs && m_tlast_q) begin
          state_d    = ST_FILL;
          wr_cnt_d   = '0;
          rd_cnt_d   = '0;
          max_d      = LANE_MIN;
          m_tvalid_d = 1'b0;
          m_tlast_d  = 1'b0;
        end else if (out_free) begin
          if (rd_cnt_q != wr_cnt_q) begin
            m_tdata_d  = sub_data;
            m_tlast_d  = (rd_cnt_q == (wr_cnt_q - CNT_W'(1)));
            m_tvalid_d = 1'b1;
            rd_cnt_d   = rd_cnt_q + CNT_W'(1);
          end else if (out_hs) begin
            m_tvalid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_FILL;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      max_q      <= LANE_MIN;
      ovf_q      <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      max_q      <= max_d;
      ovf_q      <= ovf_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

endmodule

// File: tb/tb_softmax_max_sub.sv
// tb/tb_softmax_max_sub.sv - scoreboard bench for softmax_max_sub
module tb_softmax_max_sub;

  localparam int LANES = 8;
  localparam int LW    = 16;
  localparam int DEPTH = 64;
  localparam int DW    = LANES * LW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          ovf_err;

  int tests = 0;
  int fails = 0;
  int out_cnt = 0;
  bit rnd_mode = 1'b0;
  bit rdy_pat[$];
  beat_t exp_q[$];
  logic [DW-1:0] pkt_q[$];

  softmax_max_sub #(.LANES(LANES), .LANE_W(LW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .ovf_err       (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a packet closes on tlast or after DEPTH beats; every lane of every
  // beat becomes (x - packet max), clamped to -32768.
  task automatic model_close();
    int m;
    m = -32768;
    foreach (pkt_q[j])
      for (int i = 0; i < LANES; i++)
        if (int'($signed(pkt_q[j][i*LW +: LW])) > m) m = int'($signed(pkt_q[j][i*LW +: LW]));
    foreach (pkt_q[j]) begin
      beat_t e;
      for (int i = 0; i < LANES; i++) begin
        int d;
        d = int'($signed(pkt_q[j][i*LW +: LW])) - m;
        if (d < -32768) d = -32768;
        e.data[i*LW +: LW] = 16'(d);
      end
      e.last = (j == pkt_q.size() - 1);
      exp_q.push_back(e);
    end
    pkt_q.delete();
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input logic l);
    pkt_q.push_back(d);
    if (l || pkt_q.size() == DEPTH) model_close();
  endtask

  function automatic logic [DW-1:0] all_lanes(input int v);
    logic [DW-1:0] b;
    for (int i = 0; i < LANES; i++) b[i*LW +: LW] = 16'(v);
    return b;
  endfunction

  function automatic logic [DW-1:0] rand_beat(input int lo, input int hi);
    logic [DW-1:0] b;
    for (int i = 0; i < LANES; i++) b[i*LW +: LW] = 16'(int'($urandom_range(0, hi - lo)) + lo);
    return b;
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    bit ok;
    bit done;
    done = 1'b0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #1;
      if (ok) done = 1'b1;
    end
    if (done) model_beat(d, l);
    else begin
      tests++; fails++;
      $display("FAIL send_timeout: got tready 0 expected 1");
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 3000 && !idle; c++) begin
      if (exp_q.size() == 0 && !m_axis_tvalid) idle = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("drain_done", {159'd0, idle}, 160'd1);
  endtask

  // Downstream ready: scripted pattern first, then random or always-ready.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rdy_pat.size() > 0) m_axis_tready = rdy_pat.pop_front();
      else m_axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares each output handshake against the scoreboard and checks
  // that stalled beats hold their value.
  logic [DW:0] prev_beat;
  bit prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rstn) prev_stall = 1'b0;
    else begin
      if (prev_stall) chk("stall_hold", {31'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                          {31'd0, 1'b1, prev_beat});
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_beat: got %0h expected none", m_axis_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_data", {32'd0, m_axis_tdata}, {32'd0, e.data});
          chk("out_last", {159'd0, m_axis_tlast}, {159'd0, e.last});
        end
        out_cnt++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    logic [DW-1:0] b;
    int base;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", {159'd0, s_axis_tready}, 160'd1);
    chk("rst_tvalid", {159'd0, m_axis_tvalid}, 160'd0);
    chk("rst_tlast", {159'd0, m_axis_tlast}, 160'd0);
    chk("rst_tdata", {32'd0, m_axis_tdata}, 160'd0);
    chk("rst_ovf", {159'd0, ovf_err}, 160'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Three-beat packet, max 100 in beat 1, latency check.
    b = rand_beat(-50, 50); b[15:0] = 16'(5); b[31:16] = 16'(-3);
    send_beat(b, 1'b0);
    b = rand_beat(-50, 50); b[47:32] = 16'(100);
    send_beat(b, 1'b0);
    send_beat(rand_beat(-50, 50), 1'b1);
    chk("lat_e0_tvalid", {159'd0, m_axis_tvalid}, 160'd0);
    chk("drain_tready", {159'd0, s_axis_tready}, 160'd0);
    @(posedge clk); #1;
    chk("lat_e1_tvalid", {159'd0, m_axis_tvalid}, 160'd1);
    wait_idle();

    // Extreme lane values in one packet.
    b = rand_beat(-100, 100); b[15:0] = 16'h8000; b[31:16] = 16'h7fff;
    send_beat(b, 1'b0);
    send_beat(all_lanes(-32768), 1'b1);
    wait_idle();

    // Downstream stall pattern 1,0,0,1 while draining.
    for (int j = 0; j < 3; j++) send_beat(rand_beat(-1000, 1000), 1'b0);
    send_beat(rand_beat(-1000, 1000), 1'b1);
    rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
    wait_idle();

    // Back-to-back single-beat packets.
    send_beat(all_lanes(7), 1'b1);
    chk("one_beat_tready_lo", {159'd0, s_axis_tready}, 160'd0);
    send_beat(all_lanes(-9), 1'b1);
    chk("one_beat_tready_lo2", {159'd0, s_axis_tready}, 160'd0);
    wait_idle();
    chk("one_beat_tready_hi", {159'd0, s_axis_tready}, 160'd1);

    // Random packets with random downstream backpressure.
    rnd_mode = 1'b1;
    for (int p = 0; p < 20; p++) begin
      int n;
      n = $urandom_range(1, 10);
      for (int j = 0; j < n; j++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send_beat(rand_beat(-32768, 32767), j == n - 1);
      end
    end
    wait_idle();
    rnd_mode = 1'b0;
    chk("ovf_before", {159'd0, ovf_err}, 160'd0);

    // Overflow: DEPTH+3 beats, tlast only on the final one.
    for (int j = 0; j < DEPTH + 3; j++) begin
      send_beat(rand_beat(-20000, 20000), j == DEPTH + 2);
      if (j == DEPTH - 2) chk("ovf_not_yet", {159'd0, ovf_err}, 160'd0);
      if (j == DEPTH - 1) chk("ovf_set", {159'd0, ovf_err}, 160'd1);
    end
    wait_idle();
    chk("ovf_sticky", {159'd0, ovf_err}, 160'd1);

    // Reset in the middle of a drain, then a fresh packet.
    base = out_cnt;
    for (int j = 0; j < 6; j++) send_beat(rand_beat(20000, 30000), j == 5);
    for (int c = 0; c < 100 && out_cnt < base + 3; c++) begin @(posedge clk); #1; end
    chk("mid_drain_reached", {159'd0, out_cnt >= base + 3}, 160'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_tvalid", {159'd0, m_axis_tvalid}, 160'd0);
    chk("rst_mid_tready", {159'd0, s_axis_tready}, 160'd1);
    chk("rst_mid_ovf", {159'd0, ovf_err}, 160'd0);
    exp_q.delete();
    pkt_q.delete();
    rstn = 1'b1;
    send_beat(rand_beat(-500, -100), 1'b0);
    send_beat(rand_beat(-500, -100), 1'b1);
    wait_idle();
    chk("final_queue_empty", {128'd0, 32'(exp_q.size())}, 160'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
